// File: rtl/tone_envelope.sv
// rtl/tone_envelope.sv - attack/sustain/release volume envelope between note_gen and speaker_control
module tone_envelope #(
    parameter int STEP_CYCLES  = 50000,
    parameter int ATTACK_STEP  = 16,
    parameter int RELEASE_STEP = 4,
    parameter int REST_MIN     = 500000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [21:0]        note_div_left,
    input  logic signed [15:0] audio_in_left,
    input  logic signed [15:0] audio_in_right,
    output logic signed [15:0] audio_out_left,
    output logic signed [15:0] audio_out_right,
    output logic [7:0]         env_gain,
    output logic [1:0]         env_state
);

    localparam int PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(STEP_CYCLES - 1);
    localparam logic [8:0]  ATK      = 9'(ATTACK_STEP);
    localparam logic [8:0]  REL      = 9'(RELEASE_STEP);
    localparam logic [21:0] REST_LIM = 22'(REST_MIN);

    localparam logic [1:0] S_SILENT  = 2'd0;
    localparam logic [1:0] S_ATTACK  = 2'd1;
    localparam logic [1:0] S_SUSTAIN = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    logic [1:0]    state, state_nxt;
    logic [7:0]    gain, gain_nxt;
    logic [PW-1:0] presc;
    logic [21:0]   note_prev;
    logic          tick, change, is_rest;
    logic [8:0]    atk_sum, rel_diff;
    logic signed [24:0] prod_l, prod_r;

    assign tick    = (presc == PRESC_MAX);
    assign change  = (note_div_left != note_prev);
    assign is_rest = (note_div_left == 22'd0) || (note_div_left >= REST_LIM);

    // Gain is zero-extended so it multiplies as a positive 0..255 factor.
    assign prod_l = audio_in_left  * $signed({1'b0, gain});
    assign prod_r = audio_in_right * $signed({1'b0, gain});

    // Envelope next-state: a note change takes priority and suppresses that cycle's step.
    always_comb begin
        state_nxt = state;
        gain_nxt  = gain;
        atk_sum   = {1'b0, gain} + ATK;
        rel_diff  = {1'b0, gain} - REL;
        if (change) begin
            if (is_rest) begin
                if (state != S_SILENT) state_nxt = S_RELEASE;
            end else begin
                case (state)
                    S_SILENT: begin
                        state_nxt = S_ATTACK;
                        gain_nxt  = 8'd0;
                    end
                    S_ATTACK, S_SUSTAIN: begin
                        // Retrigger: halve rather than drop to zero to avoid a click.
                        state_nxt = S_ATTACK;
                        gain_nxt  = gain >> 1;
                    end
                    default: state_nxt = S_ATTACK;
                endcase
            end
        end else if (tick) begin
            case (state)
                S_ATTACK: begin
                    if (atk_sum >= 9'd255) begin
                        gain_nxt  = 8'd255;
                        state_nxt = S_SUSTAIN;
                    end else begin
                        gain_nxt = atk_sum[7:0];
                    end
                end
                S_SUSTAIN: gain_nxt = 8'd255;
                S_RELEASE: begin
                    if ({1'b0, gain} <= REL) begin
                        gain_nxt  = 8'd0;
                        state_nxt = S_SILENT;
                    end else begin
                        gain_nxt = rel_diff[7:0];
                    end
                end
                default: gain_nxt = 8'd0;
            endcase
        end
    end

    // Free-running envelope tick prescaler.
    always_ff @(posedge clk) begin
        if (reset) presc <= '0;
        else if (tick) presc <= '0;
        else presc <= presc + 1'b1;
    end

    // Envelope state, gain and note history registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_SILENT;
            gain      <= 8'd0;
            note_prev <= 22'd0;
        end else begin
            state     <= state_nxt;
            gain      <= gain_nxt;
            note_prev <= note_div_left;
        end
    end

    // Registered scaled outputs using the gain held before this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            audio_out_left  <= 16'sd0;
            audio_out_right <= 16'sd0;
        end else begin
            audio_out_left  <= 16'(prod_l >>> 8);
            audio_out_right <= 16'(prod_r >>> 8);
        end
    end

    assign env_gain  = gain;
    assign env_state = state;

endmodule

// File: tb/tb_tone_envelope.sv
// tb/tb_tone_envelope.sv - directed vector bench for tone_envelope
module tb_tone_envelope;

    logic               clk = 1'b0;
    logic               reset;
    logic [21:0]        note_div_left;
    logic signed [15:0] audio_in_left, audio_in_right;
    logic signed [15:0] audio_out_left, audio_out_right;
    logic [7:0]         env_gain;
    logic [1:0]         env_state;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic               rst;
        logic [21:0]        note;
        int                 cycles;
        logic [1:0]         st;
        logic [7:0]         g;
        logic signed [15:0] ol;
        logic signed [15:0] orr;
    } vec_t;

    vec_t vecs[$];

    tone_envelope #(
        .STEP_CYCLES(4), .ATTACK_STEP(16), .RELEASE_STEP(4), .REST_MIN(500000)
    ) dut (
        .clk(clk), .reset(reset), .note_div_left(note_div_left),
        .audio_in_left(audio_in_left), .audio_in_right(audio_in_right),
        .audio_out_left(audio_out_left), .audio_out_right(audio_out_right),
        .env_gain(env_gain), .env_state(env_state)
    );

    always #5 clk = ~clk;

    task automatic add(input logic rst, input int note, input int cyc, input int st,
                       input int g, input int ol, input int orr);
        vec_t v;
        v.rst = rst; v.note = 22'(note); v.cycles = cyc; v.st = 2'(st);
        v.g = 8'(g); v.ol = 16'(ol); v.orr = 16'(orr);
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int st, input int g, input int ol, input int orr);
        n_vec++;
        if (env_state !== 2'(st) || env_gain !== 8'(g) ||
            audio_out_left !== 16'(ol) || audio_out_right !== 16'(orr)) begin
            n_bad++;
            $display("FAIL %s: got state=%0d gain=%0d out_l=%0d out_r=%0d, want state=%0d gain=%0d out_l=%0d out_r=%0d",
                     name, env_state, env_gain, audio_out_left, audio_out_right, st, g, ol, orr);
        end
    endtask

    initial begin
        // Attack from silence, retrigger on a tick edge, full release, release-to-attack at gain 100.
        add(0, 95602, 1, 1, 0, 0, 0);
        for (int k = 1; k <= 15; k++)
            add(0, 95602, (k == 1) ? 3 : 4, 1, 16 * k, 1024 * (k - 1), -1024 * (k - 1));
        add(0, 95602,   4, 2, 255, 15360, -15360);
        add(0, 95602,   1, 2, 255, 16320, -16320);
        add(0, 95602,   3, 2, 255, 16320, -16320);
        add(0, 95602,   3, 2, 255, 16320, -16320);
        add(0, 75843,   1, 1, 127, 16320, -16320);
        add(0, 75843,   4, 1, 143,  8128,  -8128);
        add(0, 75843,  28, 2, 255, 15296, -15296);
        add(0, 0,       1, 3, 255, 16320, -16320);
        add(0, 0,       3, 3, 251, 16320, -16320);
        add(0, 0,     248, 3,   3,   448,   -448);
        add(0, 0,       4, 0,   0,   192,   -192);
        add(0, 0,       1, 0,   0,     0,      0);
        add(0, 95602,   1, 1,   0,     0,      0);
        add(0, 95602,  26, 1, 112,  6144,  -6144);
        add(0, 0,       1, 3, 112,  7168,  -7168);
        add(0, 0,       3, 3, 108,  7168,  -7168);
        add(0, 0,       8, 3, 100,  6656,  -6656);
        add(0, 75843,   1, 1, 100,  6400,  -6400);
        add(0, 75843,   3, 1, 116,  6400,  -6400);
        // Rest at the REST_MIN boundary from silence, then reset during attack at gain 64.
        add(1, 75843,   1, 0,   0,     0,      0);
        add(0, 500000,  1, 0,   0,     0,      0);
        add(0, 500000,  8, 0,   0,     0,      0);
        add(0, 95602,   1, 1,   0,     0,      0);
        add(0, 95602,  14, 1,  64,  3072,  -3072);
        add(1, 95602,   1, 0,   0,     0,      0);
        add(0, 0,       2, 0,   0,     0,      0);

        reset = 1'b1;
        note_div_left  = 22'd0;
        audio_in_left  = 16'sd16384;
        audio_in_right = -16'sd16384;
        repeat (2) @(posedge clk);
        #1;
        check("reset", 0, 0, 0, 0);

        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("idle%0d", i), 0, 0, 0, 0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            reset         = vecs[i].rst;
            note_div_left = vecs[i].note;
            repeat (vecs[i].cycles) @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), vecs[i].st, vecs[i].g, vecs[i].ol, vecs[i].orr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
